fsm_mestre: RTL and testbench

Master sequencer for the bottling line. It drives one bottle through three stations: move to the fill station, fill, move to the cork station, cork, then move to the exit. It commands the conveyor FSM through the `cmd_mover`/`tarefa_concluida` handshake. It also routes the correct destination sensor to the conveyor, tracks the cork stock with its alarm, and counts finished bottles.

---
 rtl/fsm_mestre.sv | 207 ++++++++++++++++++++
 tb/tb_fsm_mestre.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_mestre.sv
// Master sequencer for the bottling line: drives one bottle through the fill
// and cork stations, handshakes with the conveyor FSM, tracks cork stock and
// counts finished bottles.
module fsm_mestre #(
  parameter int unsigned TEMPO_ENCHER = 100_000_000,
  parameter int unsigned TEMPO_VEDAR  = 25_000_000,
  parameter int unsigned ROLHAS_MAX   = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] sensores,
  input  logic       tarefa_concluida,
  input  logic       repor_rolhas,
  output logic       cmd_mover,
  output logic       sensor_destino,
  output logic       valvula_ativa,
  output logic       vedar,
  output logic       alarme_rolha,
  output logic       ocupado,
  output logic [6:0] rolhas_restantes,
  output logic [7:0] garrafas_total
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned TMR_W = 32;
  localparam int unsigned ROL_W = 7;
  localparam int unsigned GAR_W = 8;

  localparam logic [ST_W-1:0] S_IDLE         = 3'd0;
  localparam logic [ST_W-1:0] S_MOV_ENCHER   = 3'd1;
  localparam logic [ST_W-1:0] S_ENCHER       = 3'd2;
  localparam logic [ST_W-1:0] S_MOV_VEDAR    = 3'd3;
  localparam logic [ST_W-1:0] S_ESPERA_ROLHA = 3'd4;
  localparam logic [ST_W-1:0] S_VEDAR        = 3'd5;
  localparam logic [ST_W-1:0] S_MOV_SAIDA    = 3'd6;
  localparam logic [ST_W-1:0] S_FIM          = 3'd7;

  // Last timer value of each station phase (timer starts at 0 on entry).
  localparam logic [TMR_W-1:0] ENCHER_FIM = TMR_W'(TEMPO_ENCHER - 1);
  localparam logic [TMR_W-1:0] VEDAR_FIM  = TMR_W'(TEMPO_VEDAR - 1);
  localparam logic [ROL_W-1:0] ROL_CARGA  = ROL_W'(ROLHAS_MAX);

  logic [ST_W-1:0]  r_estado;
  logic [ST_W-1:0]  w_estado_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [ROL_W-1:0] r_rolhas;
  logic [ROL_W-1:0] w_rolhas_nxt;
  logic [GAR_W-1:0] r_garrafas;
  logic [GAR_W-1:0] w_garrafas_nxt;
  logic             w_tem_rolha;

  logic r_cmd_mover;
  logic r_valvula;
  logic r_vedar;
  logic r_alarme;
  logic r_ocupado;
  logic w_cmd_nxt;
  logic w_valvula_nxt;
  logic w_vedar_nxt;
  logic w_alarme_nxt;
  logic w_ocupado_nxt;
  logic w_sensor_destino;

  assign w_tem_rolha = (r_rolhas != '0);

  // Next-state, station timer, cork stock and bottle counter.
  always_comb begin
    w_estado_nxt   = r_estado;
    w_timer_nxt    = r_timer;
    w_rolhas_nxt   = r_rolhas;
    w_garrafas_nxt = r_garrafas;
    case (r_estado)
      S_IDLE: begin
        if (start && w_tem_rolha && !tarefa_concluida) begin
          w_estado_nxt = S_MOV_ENCHER;
        end
      end
      S_MOV_ENCHER: begin
        if (tarefa_concluida) begin
          w_estado_nxt = S_ENCHER;
          w_timer_nxt  = '0;
        end
      end
      S_ENCHER: begin
        // Timer saturates at the last cycle while the conveyor is still parked.
        if (r_timer >= ENCHER_FIM) begin
          if (!tarefa_concluida) begin
            w_estado_nxt = S_MOV_VEDAR;
          end
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      S_MOV_VEDAR: begin
        if (tarefa_concluida) begin
          if (w_tem_rolha) begin
            w_estado_nxt = S_VEDAR;
            w_timer_nxt  = '0;
          end else begin
            w_estado_nxt = S_ESPERA_ROLHA;
          end
        end
      end
      S_ESPERA_ROLHA: begin
        if (w_tem_rolha) begin
          w_estado_nxt = S_VEDAR;
          w_timer_nxt  = '0;
        end
      end
      S_VEDAR: begin
        if (r_timer >= VEDAR_FIM) begin
          if (!tarefa_concluida) begin
            w_estado_nxt = S_MOV_SAIDA;
            if (w_tem_rolha) begin
              w_rolhas_nxt = r_rolhas - 7'd1;
            end
          end
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      S_MOV_SAIDA: begin
        if (tarefa_concluida) begin
          w_estado_nxt = S_FIM;
        end
      end
      S_FIM: begin
        if (!tarefa_concluida) begin
          w_estado_nxt   = S_IDLE;
          w_garrafas_nxt = r_garrafas + 8'd1;
        end
      end
      default: begin
        w_estado_nxt = S_IDLE;
        w_timer_nxt  = '0;
      end
    endcase
    // A refill overrides any decrement on the same edge.
    if (repor_rolhas) begin
      w_rolhas_nxt = ROL_CARGA;
    end
  end

  // Moore outputs decoded from the next state so they register with it.
  always_comb begin
    w_cmd_nxt     = 1'b0;
    w_valvula_nxt = 1'b0;
    w_vedar_nxt   = 1'b0;
    w_alarme_nxt  = 1'b0;
    w_ocupado_nxt = (w_estado_nxt != S_IDLE);
    case (w_estado_nxt)
      S_MOV_ENCHER, S_MOV_VEDAR, S_MOV_SAIDA: w_cmd_nxt     = 1'b1;
      S_ENCHER:                               w_valvula_nxt = 1'b1;
      S_VEDAR:                                w_vedar_nxt   = 1'b1;
      S_IDLE, S_ESPERA_ROLHA:                 w_alarme_nxt  = (w_rolhas_nxt == '0);
      default:                                w_cmd_nxt     = 1'b0;
    endcase
  end

  // Destination sensor mux; combinational so the conveyor sees no added latency.
  always_comb begin
    w_sensor_destino = 1'b0;
    case (r_estado)
      S_MOV_ENCHER: w_sensor_destino = sensores[0];
      S_MOV_VEDAR:  w_sensor_destino = sensores[1];
      S_MOV_SAIDA:  w_sensor_destino = sensores[2];
      default:      w_sensor_destino = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= S_IDLE;
      r_timer     <= '0;
      r_rolhas    <= ROL_CARGA;
      r_garrafas  <= '0;
      r_cmd_mover <= 1'b0;
      r_valvula   <= 1'b0;
      r_vedar     <= 1'b0;
      r_alarme    <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      r_estado    <= w_estado_nxt;
      r_timer     <= w_timer_nxt;
      r_rolhas    <= w_rolhas_nxt;
      r_garrafas  <= w_garrafas_nxt;
      r_cmd_mover <= w_cmd_nxt;
      r_valvula   <= w_valvula_nxt;
      r_vedar     <= w_vedar_nxt;
      r_alarme    <= w_alarme_nxt;
      r_ocupado   <= w_ocupado_nxt;
    end
  end

  assign cmd_mover        = r_cmd_mover;
  assign sensor_destino   = w_sensor_destino;
  assign valvula_ativa    = r_valvula;
  assign vedar            = r_vedar;
  assign alarme_rolha     = r_alarme;
  assign ocupado          = r_ocupado;
  assign rolhas_restantes = r_rolhas;
  assign garrafas_total   = r_garrafas;

endmodule

// File: tb/tb_fsm_mestre.sv
// Bench for fsm_mestre with a small conveyor model closing the handshake.
module tb_fsm_mestre;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] sensores;
  logic       tarefa_concluida;
  logic       repor_rolhas;
  logic       cmd_mover;
  logic       sensor_destino;
  logic       valvula_ativa;
  logic       vedar;
  logic       alarme_rolha;
  logic       ocupado;
  logic [6:0] rolhas_restantes;
  logic [7:0] garrafas_total;

  int total = 0;
  int bad   = 0;

  fsm_mestre #(.TEMPO_ENCHER(4), .TEMPO_VEDAR(2), .ROLHAS_MAX(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .sensores         (sensores),
    .tarefa_concluida (tarefa_concluida),
    .repor_rolhas     (repor_rolhas),
    .cmd_mover        (cmd_mover),
    .sensor_destino   (sensor_destino),
    .valvula_ativa    (valvula_ativa),
    .vedar            (vedar),
    .alarme_rolha     (alarme_rolha),
    .ocupado          (ocupado),
    .rolhas_restantes (rolhas_restantes),
    .garrafas_total   (garrafas_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conveyor model: IDLE(0) -> MOVING(1) on cmd, raises the trip's sensor
  // after 2 cycles, PARADO(2) until cmd drops (plus optional hold at fill).
  logic [1:0] c_st;
  logic [2:0] c_cnt;
  logic [1:0] c_trip;
  logic [3:0] c_hold;
  logic [3:0] hold_fill;
  logic [2:0] c_sens;
  logic [2:0] sens_ovr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_st <= 2'd0; c_cnt <= 3'd0; c_trip <= 2'd0; c_hold <= 4'd0;
    end else begin
      case (c_st)
        2'd0: if (cmd_mover) begin c_st <= 2'd1; c_cnt <= 3'd0; end
        2'd1: begin
          if (c_cnt != 3'd7) c_cnt <= c_cnt + 3'd1;
          if (sensor_destino) begin
            c_st   <= 2'd2;
            c_hold <= (c_trip == 2'd0) ? hold_fill : 4'd0;
            c_trip <= (c_trip == 2'd2) ? 2'd0 : c_trip + 2'd1;
          end
        end
        default: if (!cmd_mover) begin
          if (c_hold != 4'd0) c_hold <= c_hold - 4'd1;
          else c_st <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    c_sens = 3'b000;
    if (c_st == 2'd1 && c_cnt >= 3'd2) c_sens = 3'b001 << c_trip;
  end

  assign sensores         = c_sens | sens_ovr;
  assign tarefa_concluida = (c_st == 2'd2);

  typedef struct {
    bit repor;
    bit go;
    int cmd;
    int valve;
    int ved;
    int rol;
    int gar;
    int alm;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_repor();
    repor_rolhas = 1'b1;
    @(negedge clk);
    repor_rolhas = 1'b0;
  endtask

  // sel: 0 valve, 1 vedar, 2 cmd_mover.
  task automatic wait_level(input int sel, input bit lvl, input string name);
    bit hit;
    bit v;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      v = (sel == 0) ? valvula_ativa : (sel == 1) ? vedar : cmd_mover;
      if (v == lvl) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL %s: timed out, level never reached %0d", name, lvl);
    end
  endtask

  task automatic wait_idle(input string name);
    bit to;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!ocupado) begin to = 1'b0; break; end
      @(negedge clk);
    end
    check(name, int'(to), 0);
  endtask

  task automatic run_bottle(input bit do_repor, input bit do_start,
                            output int n_cmd, output int n_valve,
                            output int n_ved, output bit to);
    bit prev_cmd;
    n_cmd = 0; n_valve = 0; n_ved = 0; to = 1'b1; prev_cmd = 1'b0;
    if (do_repor) pulse_repor();
    if (do_start) pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (cmd_mover && !prev_cmd) n_cmd++;
      prev_cmd = cmd_mover;
      if (valvula_ativa) n_valve++;
      if (vedar) n_ved++;
      if (!ocupado) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int nc, nv, nd, n, nt, guard;
    bit to, cmd_seen;

    vecs[0] = '{1'b0, 1'b1, 3, 4, 2, 1, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 3, 4, 2, 0, 2, 1};
    vecs[2] = '{1'b0, 1'b1, 0, 0, 0, 0, 2, 1};
    vecs[3] = '{1'b1, 1'b1, 3, 4, 2, 1, 3, 0};
    vecs[4] = '{1'b0, 1'b1, 3, 4, 2, 0, 4, 1};
    vecs[5] = '{1'b1, 1'b0, 0, 0, 0, 2, 4, 0};
    vecs[6] = '{1'b0, 1'b1, 3, 4, 2, 1, 5, 0};

    reset_n = 1'b0; start = 1'b0; repor_rolhas = 1'b0;
    sens_ovr = 3'b000; hold_fill = 4'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_rolhas", int'(rolhas_restantes), 2);
    check("rst_garrafas", int'(garrafas_total), 0);
    check("rst_cmd", int'(cmd_mover), 0);
    check("rst_valvula", int'(valvula_ativa), 0);
    check("rst_vedar", int'(vedar), 0);
    check("rst_alarme", int'(alarme_rolha), 0);
    check("rst_ocupado", int'(ocupado), 0);

    sens_ovr = 3'b111;
    #1;
    check("idle_sensor_destino", int'(sensor_destino), 0);
    sens_ovr = 3'b000;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_bottle(vecs[i].repor, vecs[i].go, nc, nv, nd, to);
      check($sformatf("v%0d_timeout", i), int'(to), 0);
      check($sformatf("v%0d_cmd_pulses", i), nc, vecs[i].cmd);
      check($sformatf("v%0d_valve_cycles", i), nv, vecs[i].valve);
      check($sformatf("v%0d_vedar_cycles", i), nd, vecs[i].ved);
      check($sformatf("v%0d_rolhas", i), int'(rolhas_restantes), vecs[i].rol);
      check($sformatf("v%0d_garrafas", i), int'(garrafas_total), vecs[i].gar);
      check($sformatf("v%0d_alarme", i), int'(alarme_rolha), vecs[i].alm);
      @(negedge clk);
    end

    // Conveyor stays parked at the fill station well past the fill time.
    hold_fill = 4'd6;
    pulse_start();
    wait_level(0, 1'b1, "hold_valve_on");
    n = 0; nt = 0; cmd_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!valvula_ativa) break;
      n++;
      if (tarefa_concluida) nt++;
      if (cmd_mover) cmd_seen = 1'b1;
      @(negedge clk);
    end
    check("hold_valve_cycles", n, 8);
    check("hold_tarefa_high_cycles", nt, 7);
    check("hold_cmd_during_fill", int'(cmd_seen), 0);
    check("hold_cmd_after_drop", int'(cmd_mover), 1);
    hold_fill = 4'd0;
    wait_idle("hold_idle_timeout");
    check("hold_rolhas", int'(rolhas_restantes), 0);
    check("hold_garrafas", int'(garrafas_total), 6);

    // Arrival at the cork station with an empty stock.
    pulse_repor();
    pulse_start();
    wait_level(0, 1'b1, "esp_fill_on");
    wait_level(0, 1'b0, "esp_fill_off");
    force dut.r_rolhas = 7'd0;
    wait_level(2, 1'b0, "esp_arrive");
    check("esp_vedar", int'(vedar), 0);
    check("esp_alarme", int'(alarme_rolha), 1);
    check("esp_ocupado", int'(ocupado), 1);
    release dut.r_rolhas;
    @(negedge clk);
    check("esp_still_waiting", int'(vedar), 0);
    check("esp_alarme_hold", int'(alarme_rolha), 1);
    pulse_repor();
    check("esp_vedar_refill_edge", int'(vedar), 0);
    check("esp_rolhas_refill", int'(rolhas_restantes), 2);
    check("esp_alarme_clear", int'(alarme_rolha), 0);
    @(negedge clk);
    check("esp_vedar_rise", int'(vedar), 1);
    wait_idle("esp_idle_timeout");
    check("esp_rolhas_end", int'(rolhas_restantes), 1);
    check("esp_garrafas", int'(garrafas_total), 7);

    // Refill on the same edge as the cork decrement.
    pulse_start();
    wait_level(1, 1'b1, "coin_vedar_on");
    @(negedge clk);
    check("coin_vedar_second", int'(vedar), 1);
    pulse_repor();
    check("coin_vedar_off", int'(vedar), 0);
    check("coin_rolhas", int'(rolhas_restantes), 2);
    wait_idle("coin_idle_timeout");
    check("coin_garrafas", int'(garrafas_total), 8);

    // Bottle counter wrap.
    guard = 0;
    while (garrafas_total != 8'd255 && guard < 300) begin
      run_bottle(1'b1, 1'b1, nc, nv, nd, to);
      if (to) check("wrap_bottle_timeout", int'(to), 0);
      guard++;
    end
    check("wrap_255", int'(garrafas_total), 255);
    run_bottle(1'b1, 1'b1, nc, nv, nd, to);
    check("wrap_last_timeout", int'(to), 0);
    check("wrap_zero", int'(garrafas_total), 0);

    // Reset in the middle of a bottle aborts it.
    @(negedge clk);
    pulse_start();
    wait_level(0, 1'b1, "midrst_valve_on");
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ocupado", int'(ocupado), 0);
    check("midrst_valvula", int'(valvula_ativa), 0);
    check("midrst_rolhas", int'(rolhas_restantes), 2);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_garrafas", int'(garrafas_total), 0);
    check("midrst_idle", int'(ocupado), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
